muldiv_sequencer: RTL

- Iterative multiply/divide controller in the EX stage, beside the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU over several cycles using a shift-add / restoring-divide datapath under FSM control.
- Owns the HI/LO registers and serves MFHI, MFLO, MTHI and MTLO.
- Raises a stall to the hazard unit while a result is pending.

---
 rtl/muldiv_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add multiply,
// restoring divide, owns HI/LO and stalls the pipeline while a result is pending.
module muldiv_sequencer #(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 32,
    parameter int NB_CNT  = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_flush,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_busy,
    output logic               o_stall,
    output logic               o_done
);
    localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(6'b011000);
    localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(6'b011001);
    localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(6'b011010);
    localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(6'b011011);
    localparam logic [NB_OP-1:0] OP_MFHI  = NB_OP'(6'b010000);
    localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(6'b010001);
    localparam logic [NB_OP-1:0] OP_MFLO  = NB_OP'(6'b010010);
    localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(6'b010011);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                state_q;
    logic [NB_CNT-1:0]     cnt_q;
    logic [2*NB_DATA-1:0]  acc_q, acc_d;
    logic [NB_DATA-1:0]    opB_q, hi_q, lo_q, hiFix_d, loFix_d;
    logic                  isDiv_q, negRes_q, negRem_q, divZero_q, busy_q, done_q;

    logic                  isMulDiv, isSigned, isDivOp;
    logic [NB_DATA-1:0]    absA, absB;
    logic [NB_DATA:0]      mulSum, remShift, remSub;
    logic [2*NB_DATA-1:0]  prod;

    always_comb begin
        isMulDiv = (i_op == OP_MULT) || (i_op == OP_MULTU) || (i_op == OP_DIV) || (i_op == OP_DIVU);
        isSigned = (i_op == OP_MULT) || (i_op == OP_DIV);
        isDivOp  = (i_op == OP_DIV) || (i_op == OP_DIVU);
        absA     = (isSigned && i_data_a[NB_DATA-1]) ? -i_data_a : i_data_a;
        absB     = (isSigned && i_data_b[NB_DATA-1]) ? -i_data_b : i_data_b;
    end

    // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mulSum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + (acc_q[0] ? {1'b0, opB_q} : '0);
        remShift = acc_q[2*NB_DATA-1:NB_DATA-1];
        remSub   = remShift - {1'b0, opB_q};
        acc_d    = {mulSum, acc_q[NB_DATA-1:1]};
        if (isDiv_q) begin
            if (remShift >= {1'b0, opB_q})
                acc_d = {remSub[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
            else
                acc_d = {remShift[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
        end
    end

    // Divide by zero leaves |a| as remainder, so only the quotient needs overriding
    always_comb begin
        prod    = negRes_q ? -acc_q : acc_q;
        hiFix_d = prod[2*NB_DATA-1:NB_DATA];
        loFix_d = prod[NB_DATA-1:0];
        if (isDiv_q) begin
            hiFix_d = negRem_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
            if (divZero_q)
                loFix_d = '1;
            else
                loFix_d = negRes_q ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (i_flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && isMulDiv) begin
                        acc_q     <= {{NB_DATA{1'b0}}, absA};
                        opB_q     <= absB;
                        isDiv_q   <= isDivOp;
                        negRes_q  <= isSigned && (i_data_a[NB_DATA-1] ^ i_data_b[NB_DATA-1]);
                        negRem_q  <= isSigned && i_data_a[NB_DATA-1];
                        divZero_q <= isDivOp && (i_data_b == '0);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else if (i_start && i_op == OP_MTHI) begin
                        hi_q <= i_data_a;
                    end else if (i_start && i_op == OP_MTLO) begin
                        lo_q <= i_data_a;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == NB_CNT'(NB_DATA - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hiFix_d;
                    lo_q    <= loFix_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_data = '0;
        if (i_start && i_op == OP_MFHI)
            o_data = hi_q;
        else if (i_start && i_op == OP_MFLO)
            o_data = lo_q;
    end

    assign o_stall = i_start && (busy_q || (state_q == IDLE && isMulDiv));
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
